// File: rtl/mpeg_pkg.sv
// mpeg_pkg: shared DCT block geometry and scheduler state encoding
package mpeg_pkg;
  localparam int BLK_DIM = 8;
  localparam int BLK_PIX = 64;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_RDY, HANDOFF, NEXT, DONE, KILL} sched_state_t;
endpackage

// File: rtl/dct_blk_addr_gen.sv
// dct_blk_addr_gen: raster walk over 8x8 blocks producing each block's source base address
module dct_blk_addr_gen
  import mpeg_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int BLK_W  = 6
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              clr,
  input  logic              step,
  input  logic [BLK_W-1:0]  cols,
  input  logic [BLK_W-1:0]  rows,
  output logic [ADDR_W-1:0] src_base,
  output logic [BLK_W-1:0]  blk_x,
  output logic [BLK_W-1:0]  blk_y,
  output logic              last_blk
);
  logic [ADDR_W-1:0] col_off, row_base;
  logic x_more, y_more;
  assign x_more   = blk_x < cols - BLK_W'(1);
  assign y_more   = blk_y < rows - BLK_W'(1);
  assign last_blk = !x_more && !y_more;
  assign src_base = row_base + col_off;
  always_ff @(posedge clk or negedge rst_in)
    if (!rst_in) begin
      blk_x    <= '0;
      blk_y    <= '0;
      col_off  <= '0;
      row_base <= '0;
    end else if (clr) begin
      blk_x    <= '0;
      blk_y    <= '0;
      col_off  <= '0;
      row_base <= '0;
    end else if (step && x_more) begin
      blk_x   <= blk_x + 1'b1;
      col_off <= col_off + ADDR_W'(BLK_DIM);
    end else if (step && y_more) begin
      blk_x    <= '0;
      col_off  <= '0;
      blk_y    <= blk_y + 1'b1;
      row_base <= row_base + ADDR_W'(cols) * ADDR_W'(BLK_PIX);
    end
endmodule

// File: rtl/dct_block_scheduler.sv
// dct_block_scheduler: frame sequencer launching the DCT engine per block with handoff, abort and watchdog
module dct_block_scheduler
  import mpeg_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int BLK_W   = 6,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              frame_start,
  input  logic              abort,
  input  logic [BLK_W-1:0]  cfg_blk_cols,
  input  logic [BLK_W-1:0]  cfg_blk_rows,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err,
  output logic              dct_start,
  input  logic              dct_ready,
  output logic              dct_rst_n,
  output logic [ADDR_W-1:0] src_base,
  output logic [BLK_W-1:0]  blk_x,
  output logic [BLK_W-1:0]  blk_y,
  output logic              res_valid,
  input  logic              res_ack
);
  sched_state_t state, state_d;
  logic [BLK_W-1:0] cols_q, rows_q;
  logic [TO_W-1:0]  wd;
  logic ready_q, kill_q, kill_d, accept, rdy_evt, wd_trip, last_blk;
  assign accept     = state == IDLE && frame_start;
  assign rdy_evt    = dct_ready && !ready_q;
  assign wd_trip    = wd == TO_W'(TIMEOUT - 1);
  assign busy       = state != IDLE;
  assign frame_done = state == DONE;
  assign dct_start  = state == LAUNCH;
  assign res_valid  = state == HANDOFF;
  // second KILL cycle is marked by kill_q; a repeated abort restarts the stretch
  assign kill_d     = state == KILL && !abort && !kill_q;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (frame_start) state_d = (cfg_blk_cols == '0 || cfg_blk_rows == '0) ? DONE : LAUNCH;
      LAUNCH:   state_d = WAIT_RDY;
      WAIT_RDY: state_d = rdy_evt ? HANDOFF : wd_trip ? KILL : WAIT_RDY;
      HANDOFF:  if (res_ack) state_d = NEXT;
      NEXT:     state_d = last_blk ? DONE : LAUNCH;
      DONE:     state_d = IDLE;
      KILL:     if (kill_q) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (abort && state != IDLE) state_d = KILL;
  end
  always_ff @(posedge clk or negedge rst_in)
    if (!rst_in) begin
      state       <= IDLE;
      cols_q      <= '0;
      rows_q      <= '0;
      wd          <= '0;
      ready_q     <= 1'b0;
      kill_q      <= 1'b0;
      timeout_err <= 1'b0;
      dct_rst_n   <= 1'b1;
    end else begin
      state       <= state_d;
      ready_q     <= dct_ready;
      kill_q      <= kill_d;
      wd          <= state == WAIT_RDY ? wd + 1'b1 : '0;
      dct_rst_n   <= state_d != KILL;
      cols_q      <= accept ? cfg_blk_cols : cols_q;
      rows_q      <= accept ? cfg_blk_rows : rows_q;
      timeout_err <= accept ? 1'b0 : (state == WAIT_RDY && wd_trip && !rdy_evt && !abort) ? 1'b1 : timeout_err;
    end
  dct_blk_addr_gen #(.ADDR_W(ADDR_W), .BLK_W(BLK_W)) u_addr (
    .clk      (clk),
    .rst_in   (rst_in),
    .clr      (accept),
    .step     (state == NEXT),
    .cols     (cols_q),
    .rows     (rows_q),
    .src_base (src_base),
    .blk_x    (blk_x),
    .blk_y    (blk_y),
    .last_blk (last_blk)
  );
endmodule

// File: tb/tb_dct_block_scheduler.sv
// tb_dct_block_scheduler: randomized scoreboard bench with an engine/result-store responder model
module tb_dct_block_scheduler;
  localparam int ADDR_W = 16, BLK_W = 6, TIMEOUT = 4096, TO_W = 13;
  logic clk = 0, rst_in = 0, frame_start = 0, abort = 0, dct_ready = 0, res_ack = 0;
  logic [BLK_W-1:0] cfg_blk_cols = '0, cfg_blk_rows = '0;
  logic busy, frame_done, timeout_err, dct_start, dct_rst_n, res_valid;
  logic [ADDR_W-1:0] src_base;
  logic [BLK_W-1:0] blk_x, blk_y;
  typedef struct {int a; int x; int y;} launch_t;
  launch_t exp_q[$];
  int done_q[$];
  launch_t cur;
  int vectors = 0, miscompares = 0, cyc = 0, done_cnt = 0, start_cnt = 0, ack_cyc = 0;
  int rdy_dly = 2, ack_dly = 1;
  bit rdy_en = 1, cur_ok = 0, ack_pend = 0;

  dct_block_scheduler #(.ADDR_W(ADDR_W), .BLK_W(BLK_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst_in(rst_in), .frame_start(frame_start), .abort(abort),
    .cfg_blk_cols(cfg_blk_cols), .cfg_blk_rows(cfg_blk_rows), .busy(busy),
    .frame_done(frame_done), .timeout_err(timeout_err), .dct_start(dct_start),
    .dct_ready(dct_ready), .dct_rst_n(dct_rst_n), .src_base(src_base),
    .blk_x(blk_x), .blk_y(blk_y), .res_valid(res_valid), .res_ack(res_ack));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation reached %0t without finishing", $time);
    $fatal(1);
  end

  task automatic chk(input string n, input int act, input int want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, want, cyc);
    end
  endtask

  // engine model: ready pulse rdy_dly cycles after each start
  initial forever begin
    @(negedge clk iff dct_start);
    if (rdy_en) begin
      repeat (rdy_dly) @(posedge clk);
      #1 dct_ready = 1;
      @(posedge clk);
      #1 dct_ready = 0;
    end
  end

  // result store model: ack pulse ack_dly cycles after valid is seen
  initial forever begin
    @(negedge clk iff res_valid);
    repeat (ack_dly) @(posedge clk);
    #1 res_ack = 1;
    @(posedge clk);
    #1 res_ack = 0;
  end

  // monitor: pops expectations whenever the DUT presents a launch or a frame end
  always @(negedge clk) begin
    cyc++;
    if (!rst_in) begin
      ack_pend = 0;
      cur_ok = 0;
    end else begin
      if (dct_start) begin
        start_cnt++;
        chk("launch_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          cur_ok = 1;
          chk("src_base", int'(src_base), cur.a);
          chk("blk_x", int'(blk_x), cur.x);
          chk("blk_y", int'(blk_y), cur.y);
        end
        if (ack_pend) chk("ack_to_start_gap", cyc - ack_cyc, 2);
        ack_pend = 0;
      end
      if (res_valid && cur_ok) chk("src_base_stable", int'(src_base), cur.a);
      if (res_valid && res_ack) begin
        ack_pend = 1;
        ack_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_expected", int'(done_q.size() != 0), 1);
        if (done_q.size() != 0) void'(done_q.pop_front());
        chk("launches_left_at_done", int'(exp_q.size()), 0);
        ack_pend = 0;
        cur_ok = 0;
      end
    end
  end

  task automatic start_frame(input int c, input int r);
    @(posedge clk);
    #1 cfg_blk_cols = BLK_W'(c); cfg_blk_rows = BLK_W'(r); frame_start = 1;
    @(posedge clk);
    #1 frame_start = 0;
  endtask

  task automatic run_frame(input int c, input int r, input int rd, input int ad);
    int d0, n, bound;
    rdy_en = 1; rdy_dly = rd; ack_dly = ad;
    for (int y = 0; y < r; y++)
      for (int x = 0; x < c; x++)
        exp_q.push_back('{a: (y * 64 * c + x * 8) % 65536, x: x, y: y});
    done_q.push_back(1);
    d0 = done_cnt; n = 0; bound = c * r * (rd + ad + 8) + 20;
    start_frame(c, r);
    while (done_cnt == d0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    chk("frame_done_count", done_cnt - d0, 1);
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    int s0, d0, n, lows;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_dct_start", int'(dct_start), 0);
    chk("rst_dct_rst_n", int'(dct_rst_n), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_src_base", int'(src_base), 0);
    chk("rst_blk_x", int'(blk_x), 0);
    chk("rst_blk_y", int'(blk_y), 0);
    @(posedge clk);
    #1 rst_in = 1;
    @(posedge clk);
    #1 abort = 1;
    @(posedge clk);
    #1 abort = 0;
    @(negedge clk);
    chk("idle_abort_busy", int'(busy), 0);
    chk("idle_abort_rst_n", int'(dct_rst_n), 1);

    run_frame(2, 2, 130, 3);
    run_frame(1, 2, 2, 50);
    for (int i = 0; i < 6; i++)
      run_frame($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 8), $urandom_range(1, 5));
    run_frame(63, 18, 1, 1);

    // watchdog: engine never answers
    rdy_en = 0;
    exp_q.push_back('{a: 0, x: 0, y: 0});
    s0 = start_cnt; d0 = done_cnt; n = 0;
    start_frame(1, 1);
    while (start_cnt == s0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    n = 0;
    while (!timeout_err && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, TIMEOUT + 1);
    lows = 0;
    for (int k = 0; k < 4; k++) begin
      lows += int'(dct_rst_n == 1'b0);
      @(negedge clk);
    end
    chk("kill_rst_low_cycles", lows, 2);
    chk("busy_after_timeout", int'(busy), 0);
    chk("timeout_sticky", int'(timeout_err), 1);
    chk("no_done_on_timeout", done_cnt - d0, 0);

    // empty frame: immediate done, no launch, clears the sticky error
    done_q.push_back(1);
    s0 = start_cnt;
    start_frame(0, 5);
    @(negedge clk);
    chk("zero_cfg_done_pulse", int'(frame_done), 1);
    chk("timeout_cleared", int'(timeout_err), 0);
    @(negedge clk);
    chk("zero_cfg_busy", int'(busy), 0);
    chk("zero_cfg_no_start", start_cnt - s0, 0);

    // abort during third block's wait; a frame_start while busy must be ignored
    rdy_en = 1; rdy_dly = 40; ack_dly = 2;
    for (int b = 0; b < 3; b++) exp_q.push_back('{a: (b / 2) * 128 + (b % 2) * 8, x: b % 2, y: b / 2});
    s0 = start_cnt; d0 = done_cnt; n = 0;
    start_frame(2, 2);
    while (start_cnt < s0 + 1 && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1 cfg_blk_cols = 5; cfg_blk_rows = 5; frame_start = 1;
    @(posedge clk);
    #1 frame_start = 0;
    n = 0;
    while (start_cnt < s0 + 3 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("third_launch_seen", start_cnt - s0, 3);
    repeat (5) @(posedge clk);
    #1 abort = 1;
    @(posedge clk);
    #1 abort = 0;
    @(negedge clk);
    chk("abort_rst_low_1", int'(dct_rst_n), 0);
    chk("abort_no_valid", int'(res_valid), 0);
    @(negedge clk);
    chk("abort_rst_low_2", int'(dct_rst_n), 0);
    @(negedge clk);
    chk("busy_after_abort", int'(busy), 0);
    chk("abort_rst_released", int'(dct_rst_n), 1);
    repeat (60) @(posedge clk);
    chk("no_done_after_abort", done_cnt - d0, 0);

    // asynchronous reset in the middle of the second block's handoff
    rdy_dly = 3; ack_dly = 20;
    exp_q.push_back('{a: 0, x: 0, y: 0});
    exp_q.push_back('{a: 8, x: 1, y: 0});
    s0 = start_cnt; n = 0;
    start_frame(2, 1);
    while (start_cnt < s0 + 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("handoff_reached", int'(res_valid), 1);
    @(negedge clk);
    #2 rst_in = 0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_res_valid", int'(res_valid), 0);
    chk("arst_src_base", int'(src_base), 0);
    chk("arst_blk_x", int'(blk_x), 0);
    chk("arst_dct_rst_n", int'(dct_rst_n), 1);
    chk("arst_dct_start", int'(dct_start), 0);
    repeat (3) @(posedge clk);
    #1 rst_in = 1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("idle_after_stray_ack", int'(busy), 0);
    chk("leftover_launches", int'(exp_q.size()), 0);
    chk("leftover_dones", int'(done_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
